// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   REG_ADDR_W : register index width (32 general registers)
//   DATA_W     : datapath width
//   R0         : index of the hardwired-zero register
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] R0 = 5'd0;
endpackage

// File: rtl/regfile_2r1w.sv
// General register file: two combinational read ports, one write port.
// Register 0 is hardwired to zero. A same-cycle write is bypassed to the read
// ports so the ID stage sees the value being committed on the coming edge.
// All registers clear asynchronously on rst.
// Ports:
//   clk, rst          : clock, asynchronous active-high clear
//   we_i, waddr_i,
//   wdata_i           : write port (committed on rising clk)
//   raddr_a_i/_b_i    : read addresses
//   rdata_a_o/_b_o    : read data
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = DATA_W,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [NREG];
  logic          wr_ok;

  // Guarding R0 here as well keeps the array consistent even if a caller
  // forgets to mask writes to register 0.
  assign wr_ok = we_i && (waddr_i != AW'(R0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] addr,
                                            input logic          wok,
                                            input logic [AW-1:0] waddr,
                                            input logic [DW-1:0] wdata,
                                            input logic [DW-1:0] stored);
    if (addr == AW'(R0))            return '0;
    else if (wok && addr == waddr)  return wdata;
    else                            return stored;
  endfunction

  assign rdata_a_o = rd_port(raddr_a_i, wr_ok, waddr_i, wdata_i, mem_q[raddr_a_i]);
  assign rdata_b_o = rd_port(raddr_b_i, wr_ok, waddr_i, wdata_i, mem_q[raddr_b_i]);

endmodule

// File: rtl/stage_wr.sv
// Write-back stage: MEM/WR pipeline register, write-back mux, overflow and
// R0 write suppression, retire counter and the general register file.
// Ports:
//   Clk, Reset           : clock, asynchronous active-high reset
//   Stall, Flush         : hold / bubble the MEM/WR register (Flush wins)
//   WRin_*               : MEM-stage results captured into MEM/WR
//   Ra, Rb / busA, busB  : ID-stage combinational read ports
//   WRout_busW/Rw/RegWr  : resolved write for forwarding
//   WRout_RetireCnt      : number of committed register writes (wraps)
module stage_wr
  import cpu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic [DW-1:0]            WRin_Dout,
  input  logic [DW-1:0]            WRin_ALUout,
  input  logic [$clog2(NREG)-1:0]  WRin_Rw,
  input  logic                     WRin_Overflow,
  input  logic                     WRin_MemtoReg,
  input  logic                     WRin_RegWr,
  input  logic [$clog2(NREG)-1:0]  Ra,
  input  logic [$clog2(NREG)-1:0]  Rb,
  output logic [DW-1:0]            busA,
  output logic [DW-1:0]            busB,
  output logic [DW-1:0]            WRout_busW,
  output logic [$clog2(NREG)-1:0]  WRout_Rw,
  output logic                     WRout_RegWr,
  output logic [31:0]              WRout_RetireCnt
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [AW-1:0] rw_q, rw_d;
  logic          ovf_q, ovf_d;
  logic          m2r_q, m2r_d;
  logic          regwr_q, regwr_d;
  logic [31:0]   retire_q, retire_d;

  logic [DW-1:0] busw;
  logic          wen;

  // MEM/WR register next state: Flush beats Stall, Stall holds.
  always_comb begin
    dout_d  = dout_q;
    alu_d   = alu_q;
    rw_d    = rw_q;
    ovf_d   = ovf_q;
    m2r_d   = m2r_q;
    regwr_d = regwr_q;
    if (Flush) begin
      dout_d  = '0;
      alu_d   = '0;
      rw_d    = '0;
      ovf_d   = 1'b0;
      m2r_d   = 1'b0;
      regwr_d = 1'b0;
    end else if (!Stall) begin
      dout_d  = WRin_Dout;
      alu_d   = WRin_ALUout;
      rw_d    = WRin_Rw;
      ovf_d   = WRin_Overflow;
      m2r_d   = WRin_MemtoReg;
      regwr_d = WRin_RegWr;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dout_q  <= '0;
      alu_q   <= '0;
      rw_q    <= '0;
      ovf_q   <= 1'b0;
      m2r_q   <= 1'b0;
      regwr_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      alu_q   <= alu_d;
      rw_q    <= rw_d;
      ovf_q   <= ovf_d;
      m2r_q   <= m2r_d;
      regwr_q <= regwr_d;
    end
  end

  // Write-back resolution straight off the MEM/WR register.
  assign busw = m2r_q ? dout_q : alu_q;
  assign wen  = regwr_q && !ovf_q && (rw_q != AW'(R0));

  // A stalled instruction keeps wen high, so it recounts every held cycle.
  assign retire_d = wen ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  regfile_2r1w #(
    .NREG (NREG),
    .DW   (DW),
    .AW   (AW)
  ) u_rf (
    .clk       (Clk),
    .rst       (Reset),
    .we_i      (wen),
    .waddr_i   (rw_q),
    .wdata_i   (busw),
    .raddr_a_i (Ra),
    .raddr_b_i (Rb),
    .rdata_a_o (busA),
    .rdata_b_o (busB)
  );

  assign WRout_busW      = busw;
  assign WRout_Rw        = rw_q;
  assign WRout_RegWr     = wen;
  assign WRout_RetireCnt = retire_q;

endmodule

// File: tb/tb_stage_wr.sv
module tb_stage_wr;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic [31:0] WRin_Dout;
  logic [31:0] WRin_ALUout;
  logic [4:0]  WRin_Rw;
  logic        WRin_Overflow;
  logic        WRin_MemtoReg;
  logic        WRin_RegWr;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [31:0] WRout_busW;
  logic [4:0]  WRout_Rw;
  logic        WRout_RegWr;
  logic [31:0] WRout_RetireCnt;

  int n_cmp = 0;
  int n_bad = 0;

  stage_wr #(.NREG(32), .DW(32)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Flush           (Flush),
    .WRin_Dout       (WRin_Dout),
    .WRin_ALUout     (WRin_ALUout),
    .WRin_Rw         (WRin_Rw),
    .WRin_Overflow   (WRin_Overflow),
    .WRin_MemtoReg   (WRin_MemtoReg),
    .WRin_RegWr      (WRin_RegWr),
    .Ra              (Ra),
    .Rb              (Rb),
    .busA            (busA),
    .busB            (busB),
    .WRout_busW      (WRout_busW),
    .WRout_Rw        (WRout_Rw),
    .WRout_RegWr     (WRout_RegWr),
    .WRout_RetireCnt (WRout_RetireCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic regwr, input logic [4:0] rw, input logic m2r,
                       input logic ovf, input logic [31:0] alu, input logic [31:0] dout);
    WRin_RegWr    = regwr;
    WRin_Rw       = rw;
    WRin_MemtoReg = m2r;
    WRin_Overflow = ovf;
    WRin_ALUout   = alu;
    WRin_Dout     = dout;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    Ra = 5'd0;
    Rb = 5'd0;
    drive(1'b1, 5'd6, 1'b0, 1'b0, 32'hCAFE0000, 32'h0);

    // Reset held: inputs must not be captured or committed.
    tick();
    tick();
    Ra = 5'd6;
    #1;
    check("rst_regwr", {31'b0, WRout_RegWr}, 32'h0);
    check("rst_busw", WRout_busW, 32'h0);
    check("rst_rw", {27'b0, WRout_Rw}, 32'h0);
    check("rst_busA", busA, 32'h0);
    check("rst_cnt", WRout_RetireCnt, 32'h0);

    bubble();
    tick();
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i);
      Rb = 5'(31 - i);
      #1;
      check($sformatf("idle_busA_r%0d", i), busA, 32'h0);
      check($sformatf("idle_busB_r%0d", 31 - i), busB, 32'h0);
    end
    tick();
    check("idle_cnt", WRout_RetireCnt, 32'h0);
    check("idle_regwr", {31'b0, WRout_RegWr}, 32'h0);

    // ALU write to r5 with bypass visible before commit.
    drive(1'b1, 5'd5, 1'b0, 1'b0, 32'h12345678, 32'h00000055);
    tick();
    Ra = 5'd5;
    #1;
    check("alu_regwr", {31'b0, WRout_RegWr}, 32'h1);
    check("alu_rw", {27'b0, WRout_Rw}, 32'h5);
    check("alu_busw", WRout_busW, 32'h12345678);
    check("alu_bypass_busA", busA, 32'h12345678);
    check("alu_cnt_pre", WRout_RetireCnt, 32'h0);
    bubble();
    tick();
    check("alu_regwr_after", {31'b0, WRout_RegWr}, 32'h0);
    check("alu_r5_stored", busA, 32'h12345678);
    check("alu_cnt", WRout_RetireCnt, 32'h1);

    // Load write to r9 selects memory data.
    drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h00000004, 32'hDEADBEEF);
    tick();
    check("ld_busw", WRout_busW, 32'hDEADBEEF);
    bubble();
    tick();
    Rb = 5'd9;
    #1;
    check("ld_r9", busB, 32'hDEADBEEF);
    check("ld_cnt", WRout_RetireCnt, 32'h2);

    // Suppressed writes: r0 target, then overflow on r7.
    drive(1'b1, 5'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0);
    tick();
    Ra = 5'd0;
    #1;
    check("sup_r0_regwr", {31'b0, WRout_RegWr}, 32'h0);
    check("sup_r0_busA", busA, 32'h0);
    drive(1'b1, 5'd7, 1'b0, 1'b1, 32'h00000077, 32'h0);
    tick();
    Ra = 5'd7;
    #1;
    check("sup_ovf_regwr", {31'b0, WRout_RegWr}, 32'h0);
    check("sup_ovf_nobypass", busA, 32'h0);
    bubble();
    tick();
    check("sup_r7", busA, 32'h0);
    Ra = 5'd0;
    #1;
    check("sup_r0_after", busA, 32'h0);
    check("sup_cnt", WRout_RetireCnt, 32'h2);

    // Stall holds r3 write for three edges; r4 inputs are ignored.
    drive(1'b1, 5'd3, 1'b0, 1'b0, 32'h0000000A, 32'h0);
    tick();
    check("stall_cnt_capture", WRout_RetireCnt, 32'h2);
    Stall = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 1'b0, 32'h0000000B, 32'h0);
    tick();
    tick();
    tick();
    Ra = 5'd3;
    Rb = 5'd4;
    #1;
    check("stall_rw_held", {27'b0, WRout_Rw}, 32'h3);
    check("stall_cnt", WRout_RetireCnt, 32'h5);
    check("stall_r3", busA, 32'h0000000A);
    check("stall_r4", busB, 32'h0);
    // Flush wins over Stall; held r3 write commits on the same edge.
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    Stall = 1'b0;
    bubble();
    #1;
    check("flush_regwr", {31'b0, WRout_RegWr}, 32'h0);
    check("flush_cnt", WRout_RetireCnt, 32'h6);
    tick();
    check("flush_r4", busB, 32'h0);
    check("flush_r3", busA, 32'h0000000A);

    // Write r1..r3, then reset between edges with r2 write in flight.
    drive(1'b1, 5'd1, 1'b0, 1'b0, 32'h00000011, 32'h0);
    tick();
    drive(1'b1, 5'd2, 1'b0, 1'b0, 32'h00000022, 32'h0);
    tick();
    drive(1'b1, 5'd3, 1'b0, 1'b0, 32'h00000033, 32'h0);
    tick();
    drive(1'b1, 5'd2, 1'b0, 1'b0, 32'h00000099, 32'h0);
    tick();
    Ra = 5'd1;
    Rb = 5'd3;
    #1;
    check("pre_rst_cnt", WRout_RetireCnt, 32'h9);
    check("pre_rst_r1", busA, 32'h00000011);
    check("pre_rst_r3", busB, 32'h00000033);
    check("pre_rst_regwr", {31'b0, WRout_RegWr}, 32'h1);
    Reset = 1'b1;
    #1;
    check("arst_cnt", WRout_RetireCnt, 32'h0);
    check("arst_regwr", {31'b0, WRout_RegWr}, 32'h0);
    check("arst_busw", WRout_busW, 32'h0);
    check("arst_r1", busA, 32'h0);
    check("arst_r3", busB, 32'h0);
    bubble();
    tick();
    Reset = 1'b0;
    tick();
    for (int i = 1; i < 4; i++) begin
      Ra = 5'(i);
      #1;
      check($sformatf("post_rst_r%0d", i), busA, 32'h0);
    end
    check("post_rst_cnt", WRout_RetireCnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_wr.md
Name: stage_wr

Overview:
Write-back stage of the 5-stage pipelined CPU. It contains the MEM/WR pipeline register, the write-back data mux, overflow write suppression, and the 32x32 general register file. It consumes the MEM-stage outputs: data-memory read data, ALU result, Rw, Overflow, MemtoReg and RegWr. It serves the ID stage's two combinational read ports and exposes the resolved write for forwarding.

Parameters:
- NREG, 32, number of general registers (index width = clog2(NREG) = 5)
- DW, 32, data width

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold MEM/WR register contents
- Flush  in  1  load a bubble into MEM/WR register
- WRin_Dout  in  32  data-memory output from MEM stage
- WRin_ALUout  in  32  ALU result from MEM stage
- WRin_Rw  in  5  destination register from MEM stage
- WRin_Overflow  in  1  ALU overflow flag from MEM stage
- WRin_MemtoReg  in  1  1 = write memory data, 0 = write ALU result
- WRin_RegWr  in  1  register write request from MEM stage
- Ra  in  5  read address A from ID stage
- Rb  in  5  read address B from ID stage
- busA  out  32  register read data A
- busB  out  32  register read data B
- WRout_busW  out  32  resolved write-back data (forwarding)
- WRout_Rw  out  5  resolved destination register (forwarding)
- WRout_RegWr  out  1  effective write enable (forwarding)
- WRout_RetireCnt  out  32  count of committed register writes

Behaviour:
- Reset (asynchronous, active-high): MEM/WR register cleared (all data 0, RegWr 0, Overflow 0, MemtoReg 0); all 32 registers cleared to 0; RetireCnt 0. While Reset is high, WRout_RegWr=0, WRout_busW=0, WRout_Rw=0, and busA/busB read 0.
- MEM/WR register update, on rising Clk, priority highest first:
  - Flush: register loads a bubble (RegWr=0, other fields 0). Flush overrides Stall.
  - Stall: register holds its contents.
  - Otherwise: register captures all WRin_* inputs.
- Write-back data: busW = MemtoReg ? Dout_q : ALUout_q. Combinational from the register, so latency is one cycle from the MEM-stage outputs to the register file.
- Effective write enable: wen = RegWr_q & ~Overflow_q & (Rw_q != 0).
  - Overflowed arithmetic results are never committed.
  - Register 0 is never written.
- Register file write: on rising Clk, when wen=1, reg[Rw_q] <= busW.
  - The write occurs even while Stall is high; Stall holds only the pipeline register.
  - A held instruction therefore rewrites the same value each cycle. This is idempotent and allowed.
- Read ports are combinational:
  - Address 0 always reads 0.
  - If wen=1 and Ra==Rw_q (Ra!=0), busA = busW. This internal bypass makes the same-cycle write visible. busB behaves identically using Rb.
  - Otherwise busA/busB return the stored register value.
- Forwarding outputs: WRout_busW = busW, WRout_Rw = Rw_q, WRout_RegWr = wen.
- RetireCnt increments by 1 on each rising edge where wen=1, wrapping modulo 2^32.
  - A write to register 0 and a suppressed overflow write do not count.
  - While Stall holds an instruction with wen=1, RetireCnt still increments every cycle.
- Reset asserted mid-operation clears all state immediately, including any write in flight. The write is lost, not partially committed.
- Flush and a valid write-back in the same cycle: the current instruction (already in the register) commits on that edge; the bubble follows.

Decomposition:
- Shared package cpu_pkg holds: REG_ADDR_W=5, DATA_W=32, and the R0 constant 5'd0.
- One natural sub-module: regfile_2r1w. It holds the 32x32 array, two combinational read ports with write bypass, R0 hardwired to zero, and asynchronous clear.
- stage_wr contains the MEM/WR register, the write-back mux, wen generation, the retire counter, and the regfile_2r1w instance.

Test Plan:
- Reset then idle: every register reads 0 on busA and busB; RetireCnt=0; WRout_RegWr=0.
- ALU write: WRin_ALUout=0x12345678, Rw=5, RegWr=1, MemtoReg=0 -> after edge 1 WRout_RegWr=1; after edge 2 reg5=0x12345678 and RetireCnt=1. With Ra=5, busA=0x12345678 already in the cycle before edge 2 (bypass).
- Load write: WRin_Dout=0xDEADBEEF, WRin_ALUout=0x4, MemtoReg=1, Rw=9 -> reg9=0xDEADBEEF, not 0x4.
- Suppression: one transfer with Rw=0 and value 0xFFFFFFFF, a second with Rw=7 and Overflow=1 -> reg0 reads 0; reg7 unchanged; RetireCnt unchanged; WRout_RegWr=0 for both.
- Stall/Flush: load Rw=3 value 0xA, hold Stall for 3 cycles while inputs change to Rw=4 -> reg4 untouched; reg3=0xA; RetireCnt +=3. Then Flush with Stall=1 -> WRout_RegWr=0 next cycle.
- Asynchronous reset mid-stream: after writing regs 1-3, pulse Reset between clock edges -> all registers read 0 and RetireCnt=0 immediately, without waiting for a clock edge.
